ifu: RTL

Instruction fetch unit for the single-issue NPC core. It owns the PC and issues word reads to instruction memory over a request/response interface. Each returned instruction word is presented, with its PC, to the decode stage over a valid/ready handshake. It sits upstream of the decoder, accepts control-flow redirects from execute, and stops fetching after it delivers `ebreak`.

---
 rtl/ifu.sv | 128 ++++++++++++
 1 files changed

// File: rtl/ifu.sv
`default_nettype none
// ============================================================================
// Module   : ifu
// Brief    : Instruction fetch unit. Owns the PC, issues one word read at a
//            time to instruction memory and hands each word to decode.
// Revision : 1.0 - initial release
// ============================================================================
module ifu #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        halted
);

    localparam logic [1:0]  c_ST_REQ  = 2'd0;
    localparam logic [1:0]  c_ST_WAIT = 2'd1;
    localparam logic [1:0]  c_ST_HOLD = 2'd2;
    localparam logic [1:0]  c_ST_HALT = 2'd3;
    localparam logic [31:0] c_EBREAK  = 32'h0010_0073;

    logic [1:0]  r_state;
    logic [31:0] r_pc;
    logic        r_discard;
    logic [31:0] r_inst;
    logic [31:0] r_inst_pc;

    logic [1:0]  w_state_nxt;
    logic [31:0] w_pc_nxt;
    logic        w_discard_nxt;
    logic        w_load_inst;
    logic [31:0] w_redirect_pc;

    assign w_redirect_pc = {redirect_pc[31:2], 2'b00};

    always_comb begin
        w_state_nxt   = r_state;
        w_pc_nxt      = r_pc;
        w_discard_nxt = r_discard;
        w_load_inst   = 1'b0;
        case (r_state)
            c_ST_REQ: begin
                if (redirect_valid) begin
                    w_pc_nxt = w_redirect_pc;
                    // The request already on the bus carries the old PC.
                    if (imem_req_ready) begin
                        w_state_nxt   = c_ST_WAIT;
                        w_discard_nxt = 1'b1;
                    end
                end else if (imem_req_ready) begin
                    w_state_nxt = c_ST_WAIT;
                end
            end
            c_ST_WAIT: begin
                if (redirect_valid) begin
                    w_pc_nxt = w_redirect_pc;
                    if (imem_rsp_valid) begin
                        w_state_nxt   = c_ST_REQ;
                        w_discard_nxt = 1'b0;
                    end else begin
                        w_discard_nxt = 1'b1;
                    end
                end else if (imem_rsp_valid) begin
                    w_state_nxt   = r_discard ? c_ST_REQ : c_ST_HOLD;
                    w_discard_nxt = 1'b0;
                    w_load_inst   = ~r_discard;
                end
            end
            c_ST_HOLD: begin
                if (redirect_valid) begin
                    w_pc_nxt    = w_redirect_pc;
                    w_state_nxt = c_ST_REQ;
                end else if (inst_ready) begin
                    if (r_inst == c_EBREAK) begin
                        w_state_nxt = c_ST_HALT;
                    end else begin
                        w_pc_nxt    = r_pc + 32'd4;
                        w_state_nxt = c_ST_REQ;
                    end
                end
            end
            c_ST_HALT: begin
                w_state_nxt = c_ST_HALT;
            end
            default: begin
                w_state_nxt = c_ST_REQ;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= c_ST_REQ;
            r_pc      <= RESET_PC;
            r_discard <= 1'b0;
            r_inst    <= 32'd0;
            r_inst_pc <= 32'd0;
        end else begin
            r_state   <= w_state_nxt;
            r_pc      <= w_pc_nxt;
            r_discard <= w_discard_nxt;
            if (w_load_inst) begin
                r_inst    <= imem_rsp_data;
                r_inst_pc <= r_pc;
            end
        end
    end

    assign imem_req_valid = (r_state == c_ST_REQ) & rst_n;
    assign imem_req_addr  = r_pc;
    assign inst_valid     = (r_state == c_ST_HOLD);
    assign inst           = r_inst;
    assign inst_pc        = r_inst_pc;
    assign halted         = (r_state == c_ST_HALT);

endmodule
`default_nettype wire
